l2_arbiter: RTL and testbench

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/l2_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_l2_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter: two-port (instruction / data) arbiter in front of the L2 cache
// control. A granted port owns the L2 bus until its transaction is acked or
// it drops its cycle; ties in IDLE alternate using last_grant. Each port keeps
// a saturating count of completed transactions.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-side requester
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat_w,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_dat_r,
  // data-side requester
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_w,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_dat_r,
  // toward L2 cache control
  output logic              l2_cyc,
  output logic              l2_stb,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_adr,
  output logic [DATA_W-1:0] l2_dat_w,
  input  logic              l2_ack,
  input  logic [DATA_W-1:0] l2_dat_r,
  // status
  output logic [1:0]        grant,
  input  logic              cnt_clr,
  output logic [15:0]       i_cnt,
  output logic [15:0]       d_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  // last_grant encoding: which port was most recently granted
  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        last_grant_r;
  logic        last_grant_nxt_s;
  logic [15:0] i_cnt_r;
  logic [15:0] d_cnt_r;
  logic        req_i_s;
  logic        req_d_s;
  logic        i_done_s;
  logic        d_done_s;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req_i_s  = i_cyc & i_stb;
  assign req_d_s  = d_cyc & d_stb;

  // A completion needs the owner still holding its cycle when L2 acks;
  // an ack coinciding with a dropped cycle is an abort, not a completion.
  assign i_done_s = (state_r == SERVE_I) & i_cyc & l2_ack;
  assign d_done_s = (state_r == SERVE_D) & d_cyc & l2_ack;

  assign i_ack    = i_done_s;
  assign d_ack    = d_done_s;
  assign i_dat_r  = l2_dat_r;
  assign d_dat_r  = l2_dat_r;

  // grant is a pure decode of the state register, so requests never reach it
  assign grant    = {(state_r == SERVE_D), (state_r == SERVE_I)};

  assign i_cnt    = i_cnt_r;
  assign d_cnt    = d_cnt_r;

  // Next-state and last_grant selection; a grant is held until ack or abort.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (req_i_s && req_d_s) begin
          if (last_grant_r == LG_D) begin
            state_nxt_s      = SERVE_I;
            last_grant_nxt_s = LG_I;
          end else begin
            state_nxt_s      = SERVE_D;
            last_grant_nxt_s = LG_D;
          end
        end else if (req_i_s) begin
          state_nxt_s      = SERVE_I;
          last_grant_nxt_s = LG_I;
        end else if (req_d_s) begin
          state_nxt_s      = SERVE_D;
          last_grant_nxt_s = LG_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE_I: begin
        if (!i_cyc || l2_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (!d_cyc || l2_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVE_D;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Route the owning port onto the L2 bus; IDLE drives an all-zero bus.
  always_comb begin
    l2_cyc   = 1'b0;
    l2_stb   = 1'b0;
    l2_we    = 1'b0;
    l2_adr   = '0;
    l2_dat_w = '0;
    case (state_r)
      SERVE_I: begin
        l2_cyc   = 1'b1;
        l2_stb   = 1'b1;
        l2_we    = i_we;
        l2_adr   = i_adr;
        l2_dat_w = i_dat_w;
      end
      SERVE_D: begin
        l2_cyc   = 1'b1;
        l2_stb   = 1'b1;
        l2_we    = d_we;
        l2_adr   = d_adr;
        l2_dat_w = d_dat_w;
      end
      default: begin
        l2_cyc = 1'b0;
      end
    endcase
  end

  // State and last_grant registers; reset leaves D as last so I wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= LG_D;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Completed-transaction counters; clear wins over a same-cycle completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt_r <= 16'd0;
      d_cnt_r <= 16'd0;
    end else if (cnt_clr) begin
      i_cnt_r <= 16'd0;
      d_cnt_r <= 16'd0;
    end else begin
      if (i_done_s) begin
        i_cnt_r <= sat_inc(i_cnt_r);
      end
      if (d_done_s) begin
        d_cnt_r <= sat_inc(d_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios followed by a randomized two-requester run.
// A scoreboard queue per port holds the expected bus view and read data of
// each issued request; a negedge monitor pops and compares on every ack and
// predicts each grant from the arbitration rules.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
  logic [31:0]  i_adr, d_adr;
  logic [255:0] i_dat_w, d_dat_w, i_dat_r, d_dat_r;
  logic         i_ack, d_ack;
  logic         l2_cyc, l2_stb, l2_we, l2_ack;
  logic [31:0]  l2_adr;
  logic [255:0] l2_dat_w, l2_dat_r;
  logic [1:0]   grant;
  logic         cnt_clr;
  logic [15:0]  i_cnt, d_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0]  adr;
    logic         we;
    logic [255:0] wdat;
    logic [255:0] rdat;
  } txn_t;

  txn_t i_q[$];
  txn_t d_q[$];

  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] l2_mem  [logic [31:0]];

  bit   resp_en = 1'b0;
  bit   mon_en  = 1'b0;
  bit   last_srv_d;
  bit   exp_g_valid;
  logic [1:0] exp_g;

  localparam int NTX = 40;

  l2_arbiter #(.ADDR_W(32), .DATA_W(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w),
    .i_ack(i_ack), .i_dat_r(i_dat_r),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w),
    .d_ack(d_ack), .d_dat_r(d_dat_r),
    .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr),
    .l2_dat_w(l2_dat_w), .l2_ack(l2_ack), .l2_dat_r(l2_dat_r),
    .grant(grant), .cnt_clr(cnt_clr), .i_cnt(i_cnt), .d_cnt(d_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Background content of L2 memory for never-written lines
  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'hC3A5_0F1E}};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    {i_cyc, i_stb, i_we, d_cyc, d_stb, d_we, l2_ack, cnt_clr} = 8'd0;
    i_adr = 32'd0; d_adr = 32'd0; i_dat_w = '0; d_dat_w = '0; l2_dat_r = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One directed zero-wait transaction on a port, optionally clearing counters in the ack cycle
  task automatic xact(input bit port_d, input logic clr);
    @(negedge clk);
    if (port_d) begin d_cyc = 1'b1; d_stb = 1'b1; end
    else begin i_cyc = 1'b1; i_stb = 1'b1; end
    @(posedge clk); #1;
    l2_ack = 1'b1; cnt_clr = clr;
    @(posedge clk); #1;
    l2_ack = 1'b0; cnt_clr = 1'b0;
    {i_cyc, i_stb, d_cyc, d_stb} = 4'd0;
  endtask

  // L2 slave model: random 0..3 cycle latency, single-cycle ack pulse
  initial begin
    int wait_c;
    wait_c = 0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        if (l2_ack) begin
          l2_ack = 1'b0;
        end else if (l2_cyc && l2_stb) begin
          if (wait_c == 0) begin
            l2_ack = 1'b1;
            if (l2_we) begin
              l2_mem[l2_adr] = l2_dat_w;
              l2_dat_r = rnd256();
            end else begin
              l2_dat_r = l2_mem.exists(l2_adr) ? l2_mem[l2_adr] : pat(l2_adr);
            end
            wait_c = $urandom_range(3, 0);
          end else begin
            wait_c--;
          end
        end
      end
    end
  end

  // Monitor: scoreboard pops on acks and rule-based grant prediction
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("ack_exclusive", {255'd0, i_ack & d_ack}, 256'd0);
        chk("cyc_vs_grant", {255'd0, l2_cyc}, {255'd0, grant != 2'b00});
        if (exp_g_valid) chk("grant_rule", {254'd0, grant}, {254'd0, exp_g});
        exp_g_valid = 1'b0;
        if (i_ack) begin
          chk("i_sb_nonempty", {255'd0, i_q.size() != 0}, 256'd1);
          if (i_q.size() != 0) begin
            t = i_q.pop_front();
            chk("i_l2_adr", {224'd0, l2_adr}, {224'd0, t.adr});
            chk("i_l2_we", {255'd0, l2_we}, {255'd0, t.we});
            chk("i_l2_dat_w", l2_dat_w, t.wdat);
            chk("i_dat_r", i_dat_r, t.rdat);
          end
        end
        if (d_ack) begin
          chk("d_sb_nonempty", {255'd0, d_q.size() != 0}, 256'd1);
          if (d_q.size() != 0) begin
            t = d_q.pop_front();
            chk("d_l2_adr", {224'd0, l2_adr}, {224'd0, t.adr});
            chk("d_l2_we", {255'd0, l2_we}, {255'd0, t.we});
            chk("d_l2_dat_w", l2_dat_w, t.wdat);
            if (!t.we) chk("d_dat_r", d_dat_r, t.rdat);
          end
        end
        if (grant == 2'b00) begin
          if ((i_cyc & i_stb) && (d_cyc & d_stb)) exp_g = last_srv_d ? 2'b01 : 2'b10;
          else if (i_cyc & i_stb) exp_g = 2'b01;
          else if (d_cyc & d_stb) exp_g = 2'b10;
          else exp_g = 2'b00;
          exp_g_valid = 1'b1;
        end else begin
          last_srv_d = grant[1];
        end
      end
    end
  end

  // Global time limit so the bench always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0]  gexp [5];
    logic [15:0] i_base;
    bit i_done_all, d_done_all;

    // ---- reset state ----
    rst_n = 1'b0;
    {i_cyc, i_stb, i_we, d_cyc, d_stb, d_we, l2_ack, cnt_clr} = 8'd0;
    i_adr = 32'd0; d_adr = 32'd0; i_dat_w = '0; d_dat_w = '0; l2_dat_r = '0;
    #1;
    chk("rst_grant", {254'd0, grant}, 256'd0);
    chk("rst_l2_cyc", {253'd0, l2_cyc, l2_stb, l2_we}, 256'd0);
    chk("rst_acks", {254'd0, i_ack, d_ack}, 256'd0);
    chk("rst_cnts", {224'd0, i_cnt, d_cnt}, 256'd0);
    do_reset();

    // ---- single I read, L2 acks 3 cycles after strobe ----
    @(negedge clk);
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 32'h100;
    @(posedge clk); #1;
    chk("rd_grant", {254'd0, grant}, 256'd1);
    chk("rd_l2_cyc", {254'd0, l2_cyc, l2_stb}, 256'd3);
    chk("rd_l2_adr", {224'd0, l2_adr}, 256'h100);
    chk("rd_l2_we", {255'd0, l2_we}, 256'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rd_no_early_ack", {254'd0, i_ack, d_ack}, 256'd0);
    end
    @(posedge clk); #1;
    l2_ack = 1'b1; l2_dat_r = pat(32'h100);
    #1;
    chk("rd_i_ack", {254'd0, i_ack, d_ack}, 256'd2);
    chk("rd_i_dat_r", i_dat_r, pat(32'h100));
    @(posedge clk); #1;
    l2_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    chk("rd_idle_after", {254'd0, grant}, 256'd0);
    chk("rd_i_cnt", {240'd0, i_cnt}, 256'd1);
    chk("rd_d_cnt", {240'd0, d_cnt}, 256'd0);

    // ---- continuous tie: alternating grants with idle gaps ----
    do_reset();
    gexp[0] = 2'b01; gexp[1] = 2'b00; gexp[2] = 2'b10; gexp[3] = 2'b00; gexp[4] = 2'b01;
    @(negedge clk);
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("tie_seq", {254'd0, grant}, {254'd0, gexp[k]});
      l2_ack = (grant != 2'b00);
    end
    chk("tie_cnts", {224'd0, i_cnt, d_cnt}, {224'd0, 16'd1, 16'd1});
    @(posedge clk); #1;
    l2_ack = 1'b0; {i_cyc, i_stb, d_cyc, d_stb} = 4'd0;
    chk("tie_cnts2", {224'd0, i_cnt, d_cnt}, {224'd0, 16'd2, 16'd1});

    // ---- D write held against a waiting I request ----
    do_reset();
    @(negedge clk);
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_adr = 32'h200; d_dat_w = {32{8'hA5}};
    @(posedge clk); #1;
    chk("wr_grant", {254'd0, grant}, 256'd2);
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 32'h300;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("wr_hold_grant", {254'd0, grant}, 256'd2);
      chk("wr_l2_we", {255'd0, l2_we}, 256'd1);
      chk("wr_l2_dat_w", l2_dat_w, {32{8'hA5}});
    end
    l2_ack = 1'b1;
    #1;
    chk("wr_d_ack", {254'd0, i_ack, d_ack}, 256'd1);
    @(posedge clk); #1;
    l2_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
    chk("wr_gap_idle", {254'd0, grant}, 256'd0);
    chk("wr_d_cnt", {240'd0, d_cnt}, 256'd1);
    @(posedge clk); #1;
    chk("wr_then_i", {254'd0, grant}, 256'd1);
    chk("wr_then_i_adr", {224'd0, l2_adr}, 256'h300);
    l2_ack = 1'b1;
    @(posedge clk); #1;
    l2_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    chk("wr_i_cnt", {240'd0, i_cnt}, 256'd1);

    // ---- abort: cycle dropped in the same cycle as l2_ack ----
    @(negedge clk);
    i_cyc = 1'b1; i_stb = 1'b1;
    @(posedge clk); #1;
    chk("ab_grant", {254'd0, grant}, 256'd1);
    @(negedge clk);
    i_cyc = 1'b0; l2_ack = 1'b1;
    #1;
    chk("ab_no_ack", {254'd0, i_ack, d_ack}, 256'd0);
    @(posedge clk); #1;
    l2_ack = 1'b0; i_stb = 1'b0;
    chk("ab_l2_cyc", {255'd0, l2_cyc}, 256'd0);
    chk("ab_i_cnt", {240'd0, i_cnt}, 256'd1);

    // ---- stray ack while idle is ignored ----
    l2_ack = 1'b1;
    #1;
    chk("idle_ack_noack", {254'd0, i_ack, d_ack}, 256'd0);
    @(posedge clk); #1;
    l2_ack = 1'b0;
    chk("idle_ack_state", {254'd0, grant}, 256'd0);
    chk("idle_ack_cnts", {224'd0, i_cnt, d_cnt}, {224'd0, 16'd1, 16'd1});

    // ---- saturation and clear priority ----
    // Preload near the top instead of running ~65k transactions.
    @(negedge clk);
    force dut.d_cnt_r = 16'hFFFE;
    #1;
    release dut.d_cnt_r;
    xact(1'b1, 1'b0);
    chk("sat_reach", {240'd0, d_cnt}, 256'hFFFF);
    xact(1'b1, 1'b0);
    chk("sat_hold", {240'd0, d_cnt}, 256'hFFFF);
    i_base = i_cnt;
    xact(1'b1, 1'b1);
    chk("clr_prio_d", {240'd0, d_cnt}, 256'd0);
    chk("clr_i", {240'd0, i_cnt}, 256'd0);
    chk("clr_i_base", {255'd0, i_base == 16'd1}, 256'd1);

    // ---- asynchronous reset during SERVE_D ----
    @(negedge clk);
    d_cyc = 1'b1; d_stb = 1'b1;
    @(posedge clk); #1;
    chk("ar_grant_d", {254'd0, grant}, 256'd2);
    @(negedge clk);
    l2_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_l2_cyc", {255'd0, l2_cyc}, 256'd0);
    chk("ar_grant", {254'd0, grant}, 256'd0);
    chk("ar_d_ack", {255'd0, d_ack}, 256'd0);
    l2_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_cyc = 1'b1; i_stb = 1'b1;
    @(posedge clk); #1;
    chk("ar_tie_i_first", {254'd0, grant}, 256'd1);
    chk("ar_d_cnt", {240'd0, d_cnt}, 256'd0);
    l2_ack = 1'b1;
    @(posedge clk); #1;
    l2_ack = 1'b0;
    {i_cyc, i_stb, d_cyc, d_stb} = 4'd0;

    // ---- randomized run with scoreboard ----
    do_reset();
    last_srv_d  = 1'b1;
    exp_g_valid = 1'b0;
    resp_en = 1'b1;
    mon_en  = 1'b1;
    i_done_all = 1'b0;
    d_done_all = 1'b0;
    fork
      begin : i_side
        txn_t t;
        int w;
        bit drop;
        for (int n = 0; n < NTX; n++) begin
          repeat ($urandom_range(3, 0)) @(posedge clk);
          #1;
          t.adr  = {1'b0, $urandom_range(255, 0) > 0 ? 26'($urandom) : 26'd0, 5'd0};
          t.we   = 1'b0;
          t.wdat = rnd256();
          t.rdat = ref_mem.exists(t.adr) ? ref_mem[t.adr] : pat(t.adr);
          i_q.push_back(t);
          i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = t.adr; i_dat_w = t.wdat;
          drop = ($urandom_range(3, 0) == 0);
          for (w = 0; w < 80; w++) begin
            @(negedge clk);
            if (i_ack) break;
            if (drop && grant == 2'b01) i_stb = 1'b0;
          end
          chk("i_wait_ack", {255'd0, w < 80}, 256'd1);
          @(posedge clk); #1;
          i_cyc = 1'b0; i_stb = 1'b0;
        end
        i_done_all = 1'b1;
      end
      begin : d_side
        txn_t t;
        int w;
        for (int n = 0; n < NTX; n++) begin
          repeat ($urandom_range(3, 0)) @(posedge clk);
          #1;
          t.adr  = {1'b1, 5'($urandom), 21'd0, 5'd0};
          t.we   = 1'($urandom);
          t.wdat = rnd256();
          if (t.we) begin
            ref_mem[t.adr] = t.wdat;
            t.rdat = '0;
          end else begin
            t.rdat = ref_mem.exists(t.adr) ? ref_mem[t.adr] : pat(t.adr);
          end
          d_q.push_back(t);
          d_cyc = 1'b1; d_stb = 1'b1; d_we = t.we; d_adr = t.adr; d_dat_w = t.wdat;
          for (w = 0; w < 80; w++) begin
            @(negedge clk);
            if (d_ack) break;
          end
          chk("d_wait_ack", {255'd0, w < 80}, 256'd1);
          @(posedge clk); #1;
          d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
        end
        d_done_all = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    mon_en  = 1'b0;
    resp_en = 1'b0;
    chk("rand_done", {254'd0, i_done_all, d_done_all}, 256'd3);
    chk("rand_i_cnt", {240'd0, i_cnt}, NTX);
    chk("rand_d_cnt", {240'd0, d_cnt}, NTX);
    chk("rand_sb_empty", {255'd0, (i_q.size() == 0) && (d_q.size() == 0)}, 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
